systolic_feeder: RTL

//  Edge driver for the N x N output-stationary PE array. Holds one N x N A operand and one N x N B operand,

---
 rtl/tpu_pkg.sv | 15 +
 rtl/systolic_feeder_if.sv | 32 +++
 rtl/systolic_feeder_lane.sv | 42 ++++
 rtl/systolic_feeder.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared encodings for the systolic array control blocks.
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } feeder_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/systolic_feeder_if.sv
// Operand-load, control and edge-stream signals between the feeder and its surroundings.
interface systolic_feeder_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int IW = $clog2(N);

  logic                 wr_en;
  logic                 wr_sel;
  logic [IW-1:0]        wr_row;
  logic [IW-1:0]        wr_col;
  logic [WIDTH-1:0]     wr_data;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 arr_clr;
  logic [N*WIDTH-1:0]   a_out;
  logic [N-1:0]         a_valid;
  logic [N*WIDTH-1:0]   b_out;
  logic [N-1:0]         b_valid;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  busy, done, arr_clr, a_out, a_valid, b_out, b_valid
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output busy, done, arr_clr, a_out, a_valid, b_out, b_valid
  );

endinterface

// File: rtl/systolic_feeder_lane.sv
// One skewed edge lane: picks operand k = s - idx while s lies inside the lane's N-cycle window.
module feeder_lane #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int IW    = $clog2(N),
  localparam int SW    = $clog2(2*N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IW-1:0]      idx,
  input  logic [SW-1:0]      s,
  input  logic               stream,
  input  logic [N*WIDTH-1:0] ops,
  output logic [WIDTH-1:0]   data,
  output logic               valid
);

  logic [SW-1:0]    k;
  logic             in_win;
  logic [WIDTH-1:0] sel;

  assign k      = s - SW'(idx);
  assign in_win = stream && (s >= SW'(idx)) && (k < SW'(N));

  always_comb begin
    sel = '0;
    for (int m = 0; m < N; m++) begin
      if (k == SW'(m)) sel = ops[m*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= in_win;
      data  <= in_win ? sel : '0;
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Holds the A/B operand buffers and sequences one skewed pass into the PE array edges.
//   state  | meaning
//   IDLE   | waiting for start, buffers writable
//   CLEAR  | one cycle of arr_clr
//   STREAM | 2N-1 cycles of skewed operands, s = 0 .. 2N-2
//   FLUSH  | N cycles letting the last products reach PE[N-1][N-1]
//   DONE   | one-cycle done pulse, buffers writable, start ignored
module systolic_feeder
  import tpu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  systolic_feeder_if.slave bus
);

  localparam int IW = $clog2(N);
  localparam int SW = $clog2(2*N);
  localparam logic [SW-1:0] S_LAST     = SW'(2*N-2);
  localparam logic [SW-1:0] FLUSH_LAST = SW'(N-1);

  feeder_state_t      state_q, state_d;
  logic [SW-1:0]      tmr_q, tmr_d;
  logic [SW-1:0]      s_d;
  logic               stream_d;
  logic               wr_ok;
  logic [WIDTH-1:0]   a_buf [N][N];
  logic [WIDTH-1:0]   b_buf [N][N];
  logic [N*WIDTH-1:0] row_ops [N];
  logic [N*WIDTH-1:0] col_ops [N];
  logic [N*WIDTH-1:0] a_data, b_data;
  logic [N-1:0]       a_vld, b_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Phase lengths come from a down-counter that reloads on entry and exits at zero.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = CLEAR;
        tmr_d   = '0;
      end
      CLEAR: begin
        state_d = STREAM;
        tmr_d   = S_LAST;
      end
      STREAM: if (tmr_q == '0) begin
        state_d = FLUSH;
        tmr_d   = FLUSH_LAST;
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
      FLUSH: if (tmr_q == '0) begin
        state_d = DONE;
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lanes register from next-state values so their outputs line up with the state they describe.
  assign stream_d = (state_d == STREAM);
  assign s_d      = S_LAST - tmr_d;
  assign wr_ok    = (state_q == IDLE) || (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_buf[r][c] <= '0;
          b_buf[r][c] <= '0;
        end
      end
    end else if (bus.wr_en && wr_ok) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (bus.wr_row == IW'(r) && bus.wr_col == IW'(c)) begin
            if (bus.wr_sel == SEL_A) a_buf[r][c] <= bus.wr_data;
            if (bus.wr_sel == SEL_B) b_buf[r][c] <= bus.wr_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.arr_clr <= 1'b0;
    end else begin
      bus.busy    <= (state_d == CLEAR) || (state_d == STREAM) || (state_d == FLUSH);
      bus.done    <= (state_d == DONE);
      bus.arr_clr <= (state_d == CLEAR);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    for (genvar m = 0; m < N; m++) begin : g_op
      assign row_ops[i][m*WIDTH +: WIDTH] = a_buf[i][m];
      assign col_ops[i][m*WIDTH +: WIDTH] = b_buf[m][i];
    end

    feeder_lane #(.WIDTH(WIDTH), .N(N)) u_row (
      .clk    (clk),
      .rst_n  (rst_n),
      .idx    (IW'(i)),
      .s      (s_d),
      .stream (stream_d),
      .ops    (row_ops[i]),
      .data   (a_data[i*WIDTH +: WIDTH]),
      .valid  (a_vld[i])
    );

    feeder_lane #(.WIDTH(WIDTH), .N(N)) u_col (
      .clk    (clk),
      .rst_n  (rst_n),
      .idx    (IW'(i)),
      .s      (s_d),
      .stream (stream_d),
      .ops    (col_ops[i]),
      .data   (b_data[i*WIDTH +: WIDTH]),
      .valid  (b_vld[i])
    );
  end

  assign bus.a_out   = a_data;
  assign bus.a_valid = a_vld;
  assign bus.b_out   = b_data;
  assign bus.b_valid = b_vld;

endmodule
